// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: control FSM and baud timer driving the TX shift register's load and shift strobes.
// Optional macro UART_TX_TWO_STOP_EN adds a second stop-bit period to every frame.
`default_nettype none

module uart_tx_ctrl #(
  parameter int DIV_W   = 16,
  parameter int MIN_DIV = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [7:0]       tx_data_in,
  input  logic             parity_en,
  input  logic             parity_odd,
  input  logic [DIV_W-1:0] baud_div,
  output logic [7:0]       tx_data,
  output logic             parity_add,
  output logic             parity_en_q,
  output logic             tx_shift_reg_en,
  output logic             tx_shift_en,
  output logic             tx_busy,
  output logic             tx_done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } state_t;

  localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] TWO_V     = DIV_W'(2);

`ifdef UART_TX_TWO_STOP_EN
  localparam logic [3:0] STOP_BITS = 4'd2;
`else
  localparam logic [3:0] STOP_BITS = 4'd1;
`endif

  state_t           state;
  state_t           state_next;
  logic             parity_odd_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] baud_cnt;
  logic [3:0]       bit_cnt;
  logic [3:0]       n_bits;
  logic             accept;
  logic             done_set;
  logic [DIV_W-1:0] div_eff;

  // Start + 8 data (+ parity) + stop bit periods.
  assign n_bits  = (parity_en_q ? 4'd9 : 4'd8) + 4'd1 + STOP_BITS;
  assign div_eff = (baud_div < MIN_DIV_V) ? MIN_DIV_V : baud_div;

  assign tx_ready   = (state == IDLE);
  assign tx_busy    = (state != IDLE);
  assign accept     = tx_valid && tx_ready;
  assign parity_add = (^tx_data) ^ parity_odd_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    tx_shift_reg_en = 1'b0;
    tx_shift_en     = 1'b0;
    done_set        = 1'b0;
    case (state)
      IDLE: begin
        if (tx_valid) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        tx_shift_reg_en = 1'b1;
        state_next      = SHIFT;
      end
      SHIFT: begin
        tx_shift_en = 1'b1;
        state_next  = WAIT;
      end
      WAIT: begin
        // With D=2 the counter is loaded with 0, so this is the exit cycle.
        if (baud_cnt == '0) begin
          if (bit_cnt == n_bits) begin
            state_next = IDLE;
            done_set   = 1'b1;
          end else begin
            state_next = SHIFT;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tx_data      <= 8'h00;
      parity_en_q  <= 1'b0;
      parity_odd_q <= 1'b0;
      div_q        <= '0;
      baud_cnt     <= '0;
      bit_cnt      <= 4'd0;
      tx_done      <= 1'b0;
    end else begin
      tx_done <= done_set;
      if (accept) begin
        tx_data      <= tx_data_in;
        parity_en_q  <= parity_en;
        parity_odd_q <= parity_odd;
        div_q        <= div_eff;
        bit_cnt      <= 4'd0;
      end
      if (state == SHIFT) begin
        bit_cnt  <= bit_cnt + 4'd1;
        baud_cnt <= div_q - TWO_V;
      end else if ((state == WAIT) && (baud_cnt != '0)) begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: scoreboard bench for uart_tx_ctrl; expected strobe/done events queued by the driver.
`default_nettype none

module tb_uart_tx_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [7:0]  tx_data_in = 8'h00;
  logic        parity_en = 1'b0;
  logic        parity_odd = 1'b0;
  logic [15:0] baud_div = 16'd0;
  logic [7:0]  tx_data;
  logic        parity_add;
  logic        parity_en_q;
  logic        tx_shift_reg_en;
  logic        tx_shift_en;
  logic        tx_busy;
  logic        tx_done;

  uart_tx_ctrl #(.DIV_W(16), .MIN_DIV(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .tx_data_in     (tx_data_in),
    .parity_en      (parity_en),
    .parity_odd     (parity_odd),
    .baud_div       (baud_div),
    .tx_data        (tx_data),
    .parity_add     (parity_add),
    .parity_en_q    (parity_en_q),
    .tx_shift_reg_en(tx_shift_reg_en),
    .tx_shift_en    (tx_shift_en),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  kind;   // 0 load, 1 shift, 2 done
    logic [31:0] at;
    logic [15:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

`ifdef UART_TX_TWO_STOP_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input logic pen, input logic par, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && pen) return par;
    return 1'b1;
  endfunction

  // Monitor: models the shift register line and checks each DUT strobe against the queue.
  logic [15:0] sr = 16'hFFFF;
  always @(negedge clock) begin
    if (reset && (tx_shift_reg_en || tx_shift_en || tx_done)) begin
      ev_t e;
      logic [1:0]  k;
      logic [15:0] v;
      chk("strobe_overlap", {31'd0, tx_shift_reg_en && tx_shift_en}, 32'd0);
      if (tx_shift_reg_en) begin
        k  = 2'd0;
        v  = {5'd0, parity_en_q, parity_add, tx_data};
        sr = {6'h3F, parity_en_q ? parity_add : 1'b1, tx_data, 1'b0};
      end else if (tx_shift_en) begin
        k  = 2'd1;
        v  = {15'd0, sr[0]};
        sr = {1'b1, sr[15:1]};
      end else begin
        k = 2'd2;
        v = {14'd0, tx_ready, tx_busy};
      end
      if (exp_q.size() == 0) begin
        chk("unexpected_event", {30'd0, k}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("evt_kind", {30'd0, k}, {30'd0, e.kind});
        chk("evt_cycle", cyc, e.at);
        chk("evt_val", {16'd0, v}, {16'd0, e.val});
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic pen, input logic podd,
                      input logic [15:0] div, input logic hold, output int a);
    int d, n, t;
    logic par;
    t = 0;
    while (!tx_ready && t < 2000) begin
      @(negedge clock);
      t++;
    end
    if (!tx_ready) begin
      chk("ready_timeout", 32'd0, 32'd1);
      a = -1;
      return;
    end
    tx_data_in = b; parity_en = pen; parity_odd = podd; baud_div = div; tx_valid = 1'b1;
    a   = cyc;
    d   = (div < 2) ? 2 : int'(div);
    n   = 9 + (pen ? 1 : 0) + STOPS;
    par = (^b) ^ podd;
    exp_q.push_back('{2'd0, 32'(a + 1), {5'd0, pen, par, b}});
    for (int k = 0; k < n; k++)
      exp_q.push_back('{2'd1, 32'(a + 2 + k * d), {15'd0, frame_bit(b, pen, par, k)}});
    exp_q.push_back('{2'd2, 32'(a + 2 + n * d), 16'h0002});
    @(negedge clock);
    if (!hold) tx_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clock);
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_strobes"}, {29'd0, tx_shift_reg_en, tx_shift_en, tx_done}, 32'd0);
    chk({tag, "_busy"}, {31'd0, tx_busy}, 32'd0);
    chk({tag, "_data"}, {22'd0, parity_en_q, parity_add, tx_data}, 32'd0);
  endtask

  initial begin
    int a, a1, a2;
    repeat (3) @(negedge clock);
    chk_reset_outputs("rst_hold");
    reset = 1'b1;
    @(negedge clock);
    chk_reset_outputs("rst_rel");
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);

    // Reset pulse while idle.
    #2 reset = 1'b0;
    #1 chk_reset_outputs("idle_rst");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("idle_rst_ready", {31'd0, tx_ready}, 32'd1);

    send(8'hA5, 1'b0, 1'b0, 16'd4, 1'b0, a);
    wait_drain();
    chk("hold_data", {24'd0, tx_data}, 32'h0000_00A5);

    send(8'hA5, 1'b1, 1'b0, 16'd4, 1'b0, a);
    wait_drain();
    chk("par_even", {31'd0, parity_add}, 32'd0);

    send(8'hA5, 1'b1, 1'b1, 16'd4, 1'b0, a);
    wait_drain();
    chk("par_odd", {31'd0, parity_add}, 32'd1);

    // Back-to-back with tx_valid held high.
    send(8'h00, 1'b0, 1'b0, 16'd2, 1'b1, a1);
    send(8'hFF, 1'b0, 1'b0, 16'd2, 1'b0, a2);
    chk("b2b_accept_gap", 32'(a2 - a1), 32'd22);
    wait_drain();

    // baud_div=0 plus input changes while busy.
    send(8'h3C, 1'b1, 1'b1, 16'd0, 1'b0, a);
    tx_data_in = 8'hC3; parity_en = 1'b0; parity_odd = 1'b0; baud_div = 16'd7;
    wait_drain();
    chk("latched_data", {23'd0, parity_add, tx_data}, 32'h0000_013C);

    // Reset after the 4th shift pulse aborts the frame.
    send(8'h96, 1'b0, 1'b0, 16'd4, 1'b0, a);
    while (cyc < a + 15) @(negedge clock);
    #2 reset = 1'b0;
    exp_q.delete();
    #1 chk_reset_outputs("abort");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("abort_ready", {31'd0, tx_ready}, 32'd1);

    send(8'h5A, 1'b1, 1'b0, 16'd3, 1'b0, a);
    wait_drain();
    repeat (10) @(negedge clock);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Control FSM and baud timer for the UART transmit path. Sits directly upstream of the TX shift register: accepts a byte over a valid/ready handshake and latches it. Computes the parity bit, then drives the shift register's load and shift strobes so that start, data (LSB first), optional parity and stop bits appear on the serial line, one every baud_div clocks.

Parameters:
DIV_W, 16, width of the baud divisor input and internal baud counter
MIN_DIV, 2, smallest effective divisor; baud_div values below this are treated as MIN_DIV

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
tx_valid  input  1  upstream byte available
tx_ready  output  1  controller can accept a byte; high only in IDLE
tx_data_in  input  8  byte to transmit, sampled on accept
parity_en  input  1  1 = append parity bit; sampled on accept
parity_odd  input  1  1 = odd parity, 0 = even; sampled on accept
baud_div  input  DIV_W  clocks per bit period; sampled on accept
tx_data  output  8  latched byte, driven to shift register data input
parity_add  output  1  parity bit for tx_data, driven to shift register
parity_en_q  output  1  latched parity_en, driven to shift register parity_en
tx_shift_reg_en  output  1  one-cycle load strobe to shift register
tx_shift_en  output  1  one-cycle shift strobe to shift register
tx_busy  output  1  frame in progress (state != IDLE)
tx_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low.
- Reset (reset=0, asynchronous) sets:
  - state = IDLE.
  - tx_data, parity_add, parity_en_q, tx_shift_reg_en, tx_shift_en, tx_busy, tx_done = 0.
  - tx_ready = 1 once reset is released.
  - Baud and bit counters = 0.
  - Reset mid-frame aborts the frame immediately; no tx_done is produced.
- States: IDLE, LOAD, SHIFT, WAIT.
- IDLE:
  - tx_ready=1.
  - Accept when tx_valid & tx_ready: latch tx_data_in, parity_en, parity_odd and effective divisor D = max(baud_div, MIN_DIV).
  - Go to LOAD.
- LOAD: one cycle.
  - tx_shift_reg_en=1.
  - parity_add = (^tx_data) XOR parity_odd_q; combinational from the latched values, valid in this cycle.
  - Go to SHIFT.
- SHIFT: one cycle.
  - tx_shift_en=1, bit_cnt increments, baud counter loads D-2.
  - If D=2, skip WAIT and go straight to WAIT's exit decision next cycle.
- WAIT:
  - Baud counter decrements each cycle.
  - At 0: if bit_cnt == N go to IDLE and pulse tx_done, else go to SHIFT.
- Timing: consecutive tx_shift_en pulses are exactly D cycles apart. The first pulse is 2 cycles after the accept cycle.
- N = number of bit periods:
  - 10 with parity disabled: start, 8 data, stop.
  - 11 with parity enabled: start, 8 data, parity, stop. The stop bit is the shift register's 1-fill.
- Frame length: accept at cycle 0 gives tx_done = 1 and tx_ready = 1 at cycle 2 + N*D.
- Back-to-back frames: a new accept may occur in the same cycle as tx_done. The line stays 1 for 2 extra cycles before the next start bit.
- tx_data and parity_add hold their values until the next accept. tx_shift_reg_en and tx_shift_en are never high in the same cycle.
- Inputs changing while busy have no effect; only values latched at accept are used.
- baud_div = 0 or 1 behaves identically to baud_div = MIN_DIV.

Optional Feature:
- Macro: UART_TX_TWO_STOP_EN.
- Defined: N increases by 1 (11 without parity, 12 with parity). This produces two stop bit periods from the shift register's 1-fill; frame length becomes 2 + N*D.
- Undefined: a single stop bit, N as above.

Test Plan:
- Reset and idle: reset=0 mid-IDLE, then release -> all strobes 0, tx_busy=0, tx_ready=1, tx_done=0.
- Byte 0xA5, parity off, baud_div=4, accept at cycle 0:
  - tx_shift_reg_en at cycle 1.
  - tx_shift_en at cycles 2, 6, 10, …, 38 (10 pulses).
  - tx_done at cycle 42.
  - Serial line reads 0,1,0,1,0,0,1,0,1,1.
- Byte 0xA5 with parity on:
  - parity_odd=0 -> parity_add=0.
  - parity_odd=1 -> parity_add=1.
  - 11 shift pulses, tx_done at cycle 46 (baud_div=4).
- Back-to-back: tx_valid held high with 0x00 then 0xFF, baud_div=2 -> second accept in the tx_done cycle (cycle 22); second load at cycle 23; no lost or duplicated byte.
- baud_div=0 -> pulse spacing 2 cycles; data and parity inputs changed mid-frame -> latched values used, frame bits unchanged.
- Reset asserted after the 4th shift pulse -> all outputs 0 asynchronously, no tx_done; after release a new frame completes normally. With UART_TX_TWO_STOP_EN defined, parity off, baud_div=4 -> 11 pulses, tx_done at cycle 46.
